sram_port_arbiter: RTL and testbench

Two-requester arbiter that shares one single-port SRAM (activation or output buffer) between the accelerator sequencer and the AXI host-access path. The accelerator has fixed priority; an optional starvation guard guarantees the host a slot after a bounded wait. The block registers the SRAM command, routes read-return valids back to the winning requester, and keeps a saturating host-stall counter for debug.

---
 rtl/sram_port_arbiter_if.sv | 48 ++++
 rtl/sram_port_arbiter.sv | 111 +++++++++++
 tb/tb_sram_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals for sram_port_arbiter.
// slave = arbiter view, master = requesters plus SRAM macro view.
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  acc_req;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_wdata;
    logic                  acc_gnt;
    logic                  acc_rvalid;

    logic                  host_req;
    logic                  host_we;
    logic [ADDR_WIDTH-1:0] host_addr;
    logic [DATA_WIDTH-1:0] host_wdata;
    logic                  host_gnt;
    logic                  host_rvalid;

    logic [DATA_WIDTH-1:0] rdata;

    logic                  sram_en;
    logic                  sram_we;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    logic [15:0]           host_stall_cnt;

    modport slave (
        input  acc_req, acc_we, acc_addr, acc_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  sram_rdata,
        output acc_gnt, acc_rvalid, host_gnt, host_rvalid, rdata,
        output sram_en, sram_we, sram_addr, sram_wdata,
        output host_stall_cnt
    );

    modport master (
        output acc_req, acc_we, acc_addr, acc_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output sram_rdata,
        input  acc_gnt, acc_rvalid, host_gnt, host_rvalid, rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata,
        input  host_stall_cnt
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Fixed-priority (accelerator first) arbiter for one single-port SRAM.
// Define ARB_STARVE_GUARD_EN to add the host starvation guard (host_wait / guard_trip).
module sram_port_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_port_arbiter_if.slave  bus
);
    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
        $error("sram_port_arbiter: MAX_WAIT must be 1..255");
    end

    logic                  guard_trip;
    logic                  acc_gnt;
    logic                  host_gnt;

    logic                  sram_en_q,    sram_en_d;
    logic                  sram_we_q,    sram_we_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q,  sram_addr_d;
    logic [DATA_WIDTH-1:0] sram_wdata_q, sram_wdata_d;
    logic                  owner_q,      owner_d;
    logic                  rvalid_q,     rvalid_d;
    logic                  rowner_q,     rowner_d;
    logic [15:0]           stall_q,      stall_d;

`ifdef ARB_STARVE_GUARD_EN
    logic [7:0] host_wait_q, host_wait_d;

    assign guard_trip = bus.host_req && (host_wait_q == 8'(MAX_WAIT));

    always_comb begin
        host_wait_d = 8'd0;
        if (bus.host_req && !host_gnt) begin
            host_wait_d = (host_wait_q == 8'(MAX_WAIT)) ? host_wait_q : host_wait_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) host_wait_q <= 8'd0;
        else        host_wait_q <= host_wait_d;
    end
`else
    assign guard_trip = 1'b0;
`endif

    // Grants are combinational but must read 0 while reset is held.
    assign acc_gnt  = rst_n && bus.acc_req && !guard_trip;
    assign host_gnt = rst_n && bus.host_req && !acc_gnt;

    always_comb begin
        sram_en_d    = acc_gnt || host_gnt;
        sram_we_d    = 1'b0;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        owner_d      = owner_q;
        if (acc_gnt) begin
            sram_we_d    = bus.acc_we;
            sram_addr_d  = bus.acc_addr;
            sram_wdata_d = bus.acc_wdata;
            owner_d      = 1'b0;
        end else if (host_gnt) begin
            sram_we_d    = bus.host_we;
            sram_addr_d  = bus.host_addr;
            sram_wdata_d = bus.host_wdata;
            owner_d      = 1'b1;
        end
        // owner travels alongside the read so rvalid lines up with sram_rdata
        rvalid_d = sram_en_q && !sram_we_q;
        rowner_d = owner_q;
        stall_d  = stall_q;
        if (bus.host_req && !host_gnt && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_en_q    <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            owner_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            rowner_q     <= 1'b0;
            stall_q      <= 16'd0;
        end else begin
            sram_en_q    <= sram_en_d;
            sram_we_q    <= sram_we_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            owner_q      <= owner_d;
            rvalid_q     <= rvalid_d;
            rowner_q     <= rowner_d;
            stall_q      <= stall_d;
        end
    end

    assign bus.acc_gnt        = acc_gnt;
    assign bus.host_gnt       = host_gnt;
    assign bus.acc_rvalid     = rvalid_q && !rowner_q;
    assign bus.host_rvalid    = rvalid_q && rowner_q;
    assign bus.rdata          = bus.sram_rdata;
    assign bus.sram_en        = sram_en_q;
    assign bus.sram_we        = sram_we_q;
    assign bus.sram_addr      = sram_addr_q;
    assign bus.sram_wdata     = sram_wdata_q;
    assign bus.host_stall_cnt = stall_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench for sram_port_arbiter: stimulus pushes expected SRAM commands and
// read returns; a negedge monitor pops and compares whenever the DUT presents them.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

    sram_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
            else             bus.sram_rdata     <= mem[bus.sram_addr];
        end
    end

    typedef struct packed {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } cmd_t;
    typedef struct packed {
        logic        host;
        logic [31:0] data;
    } rd_t;

    cmd_t cmd_q [$];
    rd_t  rd_q  [$];
    cmd_t mon_c;
    rd_t  mon_r;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with no expectation queued (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.sram_en) begin
                if (cmd_q.size() == 0) flag("cmd_unexpected");
                else begin
                    mon_c = cmd_q.pop_front();
                    chk("cmd_we", 32'(bus.sram_we), 32'(mon_c.we));
                    chk("cmd_addr", 32'(bus.sram_addr), 32'(mon_c.addr));
                    if (mon_c.we) chk("cmd_wdata", bus.sram_wdata, mon_c.wdata);
                end
            end
            if (bus.acc_rvalid || bus.host_rvalid) begin
                if (bus.acc_rvalid && bus.host_rvalid) flag("rvalid_both");
                if (rd_q.size() == 0) flag("rvalid_unexpected");
                else begin
                    mon_r = rd_q.pop_front();
                    chk("rvalid_owner", 32'(bus.host_rvalid), 32'(mon_r.host));
                    chk("rdata", bus.rdata, mon_r.data);
                end
            end
        end
    end

    task automatic idle();
        bus.acc_req = 1'b0;  bus.acc_we = 1'b0;  bus.acc_addr = '0;  bus.acc_wdata = '0;
        bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    endtask

    task automatic drive_acc(input logic we, input logic [9:0] a, input logic [31:0] d);
        bus.acc_req = 1'b1; bus.acc_we = we; bus.acc_addr = a; bus.acc_wdata = d;
    endtask

    task automatic drive_host(input logic we, input logic [9:0] a, input logic [31:0] d);
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
    endtask

    task automatic next_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnts(input string name, input logic exp_acc, input logic exp_host);
        @(negedge clk);
        chk({name, "_acc_gnt"}, 32'(bus.acc_gnt), 32'(exp_acc));
        chk({name, "_host_gnt"}, 32'(bus.host_gnt), 32'(exp_host));
    endtask

    task automatic reset_dut();
        idle();
        rst_n = 1'b0;
        cmd_q.delete();
        rd_q.delete();
        next_drive();
        next_drive();
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic exp_host;
        logic host_pending;
        int   k;

        idle();
        bus.acc_req  = 1'b1;
        bus.host_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_acc_gnt", 32'(bus.acc_gnt), 32'd0);
        chk("rst_host_gnt", 32'(bus.host_gnt), 32'd0);
        chk("rst_sram_en", 32'(bus.sram_en), 32'd0);
        chk("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
        chk("rst_sram_wdata", bus.sram_wdata, 32'd0);
        chk("rst_rvalid", 32'({bus.acc_rvalid, bus.host_rvalid}), 32'd0);
        chk("rst_stall", 32'(bus.host_stall_cnt), 32'd0);
        idle();
        next_drive();
        rst_n = 1'b1;

        drive_acc(1'b1, 10'h005, 32'hDEADBEEF);
        cmd_q.push_back('{1'b1, 10'h005, 32'hDEADBEEF});
        chk_gnts("wr05", 1'b1, 1'b0);
        next_drive();
        idle();

        // lone host read, with explicit T / T+1 / T+2 latency checks
        drive_host(1'b0, 10'h005, 32'h0);
        cmd_q.push_back('{1'b0, 10'h005, 32'h0});
        rd_q.push_back('{1'b1, 32'hDEADBEEF});
        chk_gnts("rd05", 1'b0, 1'b1);
        next_drive();
        idle();
        @(negedge clk);
        chk("rd05_t1_en", 32'(bus.sram_en), 32'd1);
        chk("rd05_t1_addr", 32'(bus.sram_addr), 32'h005);
        chk("rd05_t1_rvalid", 32'(bus.host_rvalid), 32'd0);
        @(negedge clk);
        chk("rd05_t2_host_rvalid", 32'(bus.host_rvalid), 32'd1);
        chk("rd05_t2_acc_rvalid", 32'(bus.acc_rvalid), 32'd0);
        chk("rd05_t2_rdata", bus.rdata, 32'hDEADBEEF);
        next_drive();

        drive_acc(1'b1, 10'h010, 32'h11);
        drive_host(1'b0, 10'h010, 32'h0);
        cmd_q.push_back('{1'b1, 10'h010, 32'h11});
        chk_gnts("simul_c0", 1'b1, 1'b0);
        next_drive();
        bus.acc_req = 1'b0;
        cmd_q.push_back('{1'b0, 10'h010, 32'h0});
        rd_q.push_back('{1'b1, 32'h11});
        chk_gnts("simul_c1", 1'b0, 1'b1);
        next_drive();
        idle();

        // back-to-back reads alternating owners
        drive_acc(1'b0, 10'h005, 32'h0);
        cmd_q.push_back('{1'b0, 10'h005, 32'h0});
        rd_q.push_back('{1'b0, 32'hDEADBEEF});
        chk_gnts("b2b_0", 1'b1, 1'b0);
        next_drive();
        idle();
        drive_host(1'b0, 10'h010, 32'h0);
        cmd_q.push_back('{1'b0, 10'h010, 32'h0});
        rd_q.push_back('{1'b1, 32'h11});
        chk_gnts("b2b_1", 1'b0, 1'b1);
        next_drive();
        idle();
        drive_acc(1'b0, 10'h010, 32'h0);
        cmd_q.push_back('{1'b0, 10'h010, 32'h0});
        rd_q.push_back('{1'b0, 32'h11});
        chk_gnts("b2b_2", 1'b1, 1'b0);
        next_drive();
        idle();
        repeat (3) next_drive();
        chk("stall_after_simul", 32'(bus.host_stall_cnt), 32'd1);

        // reset while a read is in flight: the return must be dropped
        drive_acc(1'b0, 10'h005, 32'h0);
        cmd_q.push_back('{1'b0, 10'h005, 32'h0});
        chk_gnts("rstmid", 1'b1, 1'b0);
        next_drive();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_acc_gnt", 32'(bus.acc_gnt), 32'd0);
        chk("rstmid_sram_en", 32'(bus.sram_en), 32'd0);
        chk("rstmid_sram_addr", 32'(bus.sram_addr), 32'd0);
        chk("rstmid_rvalid", 32'({bus.acc_rvalid, bus.host_rvalid}), 32'd0);
        chk("rstmid_stall", 32'(bus.host_stall_cnt), 32'd0);
        idle();
        next_drive();
        next_drive();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rstmid_post_rvalid", 32'({bus.acc_rvalid, bus.host_rvalid}), 32'd0);
        end
        next_drive();

        // 20 cycles of accelerator traffic against a waiting host read
        host_pending = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_host = (i == 8);
`else
            exp_host = 1'b0;
`endif
            drive_acc(1'b1, 10'(10'h100 + k), 32'(k));
            if (host_pending) drive_host(1'b0, 10'h005, 32'h0);
            else              bus.host_req = 1'b0;
            chk_gnts("starve", !exp_host, exp_host);
            if (exp_host) begin
                cmd_q.push_back('{1'b0, 10'h005, 32'h0});
                rd_q.push_back('{1'b1, 32'hDEADBEEF});
                host_pending = 1'b0;
            end else begin
                cmd_q.push_back('{1'b1, 10'(10'h100 + k), 32'(k)});
                k++;
            end
            next_drive();
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("starve_stall", 32'(bus.host_stall_cnt), 32'd8);
        idle();
`else
        chk("starve_stall", 32'(bus.host_stall_cnt), 32'd20);
        bus.acc_req = 1'b0;
        cmd_q.push_back('{1'b0, 10'h005, 32'h0});
        rd_q.push_back('{1'b1, 32'hDEADBEEF});
        chk_gnts("starve_release", 1'b0, 1'b1);
        chk("starve_stall_release", 32'(bus.host_stall_cnt), 32'd20);
        next_drive();
        idle();
        repeat (3) next_drive();

        // saturation of the stall counter
        reset_dut();
        drive_acc(1'b1, 10'h200, 32'hA5);
        drive_host(1'b0, 10'h010, 32'h0);
        for (int n = 1; n <= 70000; n++) begin
            cmd_q.push_back('{1'b1, 10'h200, 32'hA5});
            next_drive();
            if (n == 65534) chk("stall_fffe", 32'(bus.host_stall_cnt), 32'h0000FFFE);
            if (n == 65535) chk("stall_ffff", 32'(bus.host_stall_cnt), 32'h0000FFFF);
        end
        chk("stall_sat_hold", 32'(bus.host_stall_cnt), 32'h0000FFFF);
        bus.acc_req = 1'b0;
        cmd_q.push_back('{1'b0, 10'h010, 32'h0});
        rd_q.push_back('{1'b1, 32'h11});
        chk_gnts("sat_release", 1'b0, 1'b1);
        next_drive();
        idle();
`endif
        repeat (4) next_drive();
        chk("cmd_q_drained", 32'(cmd_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
